// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares the synchronous data-memory port between the CPU MEM stage
//            and the debug/loader port; fixed CPU priority with debug
//            starvation guard, three-cycle access sequence, misalign reject.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_size,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [2:0]        dbg_size,
  output logic              dbg_ready,
  output logic              dbg_done,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [1:0]         c_OWN_NONE   = 2'b00;
  localparam logic [1:0]         c_OWN_CPU    = 2'b01;
  localparam logic [1:0]         c_OWN_DBG    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_CNT_W-1:0]  r_starve;
  logic                r_we;
  logic                r_mis;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_size;
  logic [1:0]          r_owner;

  logic                w_dbg_win;
  logic                w_cpu_win;
  logic                w_accept;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [2:0]          w_sel_size;

  // Size code 11 has no defined width and is checked as a word.
  function automatic logic f_misalign(input logic [2:0] size, input logic [1:0] a);
    logic res;
    res = 1'b0;
    case (size[1:0])
      2'b01:        res = a[0];
      2'b10, 2'b11: res = |a;
      default:      res = 1'b0;
    endcase
    return res;
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_dbg_win    = 1'b0;
    w_cpu_win    = 1'b0;
    mem_en       = 1'b0;
    owner        = c_OWN_NONE;
    case (r_state)
      S_IDLE: begin
        w_dbg_win = dbg_req && (!cpu_req || (r_starve == c_STARVE_MAX));
        w_cpu_win = cpu_req && !w_dbg_win;
        if (w_dbg_win || w_cpu_win) w_next_state = S_ACCESS;
      end
      S_ACCESS: begin
        mem_en       = !r_mis;
        owner        = r_owner;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        owner        = r_owner;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_accept    = w_dbg_win || w_cpu_win;
  assign cpu_ready   = w_cpu_win;
  assign dbg_ready   = w_dbg_win;
  assign w_sel_we    = w_dbg_win ? dbg_we    : cpu_we;
  assign w_sel_addr  = w_dbg_win ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = w_dbg_win ? dbg_wdata : cpu_wdata;
  assign w_sel_size  = w_dbg_win ? dbg_size  : cpu_size;

  assign mem_we    = r_we & mem_en;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_size  = r_size;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= 3'b000;
      r_owner <= c_OWN_NONE;
    end else if (w_accept) begin
      r_we    <= w_sel_we;
      r_mis   <= f_misalign(w_sel_size, w_sel_addr[1:0]);
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
      r_size  <= w_sel_size;
      r_owner <= w_dbg_win ? c_OWN_DBG : c_OWN_CPU;
    end
  end

  // Counts arbitrations debug lost while it was actually waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_dbg_win || !dbg_req)
        r_starve <= '0;
      else if (w_cpu_win && (r_starve != c_STARVE_MAX))
        r_starve <= r_starve + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_done  <= 1'b0;
      dbg_done  <= 1'b0;
      cpu_err   <= 1'b0;
      dbg_err   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      cpu_err  <= 1'b0;
      dbg_err  <= 1'b0;
      if (r_state == S_RESP) begin
        if (r_owner == c_OWN_CPU) begin
          cpu_done <= 1'b1;
          cpu_err  <= r_mis;
          if (!r_we && !r_mis) cpu_rdata <= mem_rdata;
        end else if (r_owner == c_OWN_DBG) begin
          dbg_done <= 1'b1;
          dbg_err  <= r_mis;
          if (!r_we && !r_mis) dbg_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Directed and randomized bench for dmem_port_arbiter against a
//            transaction-level model (grant rules, timing, memory contents).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  localparam int c_M_QUIET  = 0;
  localparam int c_M_FIXED  = 1;
  localparam int c_M_BOTH   = 2;
  localparam int c_M_RANDOM = 3;

  logic              clk;
  logic              rst;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
  logic [2:0]        cpu_size, dbg_size;
  logic              cpu_ready, cpu_done, cpu_err, dbg_ready, dbg_done, dbg_err;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [2:0]        mem_size;
  logic [1:0]        owner;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_size(dbg_size), .dbg_ready(dbg_ready), .dbg_done(dbg_done), .dbg_err(dbg_err),
    .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read word memory seen by the DUT.
  logic [31:0] sim_mem [0:63];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sim_mem[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= sim_mem[mem_addr[7:2]];
    end
  end

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } req_t;

  req_t cpu_q[$];
  req_t dbg_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] ref_mem [0:63];
  int          cyc, mode, starve, t_acc;
  bit          busy, t_we, t_mis, cpu_acc, dbg_acc;
  logic [1:0]  t_own;
  logic [7:0]  t_addr;
  logic [31:0] t_wdata, t_exp, exp_cpu_rd, exp_dbg_rd;
  logic [2:0]  t_size;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit misaligned(input logic [2:0] size, input logic [7:0] addr);
    int nbytes;
    nbytes = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
    return (int'(addr) % nbytes) != 0;
  endfunction

  function automatic req_t rand_req(input bit read_only);
    req_t r;
    int   pick;
    pick    = $urandom_range(0, 4);
    r.size  = (pick == 0) ? 3'b000 : (pick == 1) ? 3'b001 : (pick == 2) ? 3'b010 :
              (pick == 3) ? 3'b100 : 3'b101;
    r.we    = read_only ? 1'b0 : 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    r.addr  = 8'($urandom_range(0, 255));
    if (read_only) r.size = 3'b010;
    if (read_only || $urandom_range(0, 3) != 0)
      r.addr = (r.size[1:0] == 2'b00) ? r.addr :
               (r.size[1:0] == 2'b01) ? (r.addr & 8'hFE) : (r.addr & 8'hFC);
    return r;
  endfunction

  task automatic drive_cpu(input req_t r);
    cpu_we = r.we; cpu_addr = r.addr; cpu_wdata = r.wdata; cpu_size = r.size;
  endtask

  task automatic drive_dbg(input req_t r);
    dbg_we = r.we; dbg_addr = r.addr; dbg_wdata = r.wdata; dbg_size = r.size;
  endtask

  // Compare everything visible just after a rising edge.
  task automatic observe();
    bit done_c, done_d, exp_en;
    done_c = 1'b0; done_d = 1'b0; exp_en = 1'b0;
    cyc++;
    if (busy && cyc == t_acc + 3) begin
      done_c = (t_own == 2'b01);
      done_d = (t_own == 2'b10);
      if (!t_we && !t_mis) begin
        if (done_c) exp_cpu_rd = t_exp;
        else        exp_dbg_rd = t_exp;
      end
      busy = 1'b0;
    end
    if (busy && cyc == t_acc + 1 && !t_mis) exp_en = 1'b1;
    chk_eq("cpu_done", 32'(cpu_done), 32'(done_c));
    chk_eq("dbg_done", 32'(dbg_done), 32'(done_d));
    if (done_c) chk_eq("cpu_err", 32'(cpu_err), 32'(t_mis));
    if (done_d) chk_eq("dbg_err", 32'(dbg_err), 32'(t_mis));
    chk_eq("mem_en", 32'(mem_en), 32'(exp_en));
    chk_eq("mem_we", 32'(mem_we), 32'(exp_en && t_we));
    chk_eq("owner", 32'(owner), busy ? 32'(t_own) : 32'd0);
    chk_eq("cpu_rdata", cpu_rdata, exp_cpu_rd);
    chk_eq("dbg_rdata", dbg_rdata, exp_dbg_rd);
    if (exp_en) begin
      chk_eq("mem_addr", 32'(mem_addr), 32'(t_addr));
      chk_eq("mem_size", 32'(mem_size), 32'(t_size));
      if (t_we) chk_eq("mem_wdata", mem_wdata, t_wdata);
    end
  endtask

  // Inputs for the coming cycle; requests are only changed here.
  task automatic stim();
    req_t r;
    if (mode == c_M_QUIET) begin
      cpu_req = 1'b0; dbg_req = 1'b0;
    end
    if (cpu_acc) begin
      cpu_acc = 1'b0;
      if (mode == c_M_BOTH) drive_cpu(rand_req(1'b1));
      else cpu_req = 1'b0;
    end
    if (dbg_acc) begin
      dbg_acc = 1'b0;
      if (mode == c_M_BOTH) drive_dbg(rand_req(1'b1));
      else dbg_req = 1'b0;
    end
    case (mode)
      c_M_FIXED: begin
        if (!cpu_req && cpu_q.size() > 0) begin r = cpu_q.pop_front(); drive_cpu(r); cpu_req = 1'b1; end
        if (!dbg_req && dbg_q.size() > 0) begin r = dbg_q.pop_front(); drive_dbg(r); dbg_req = 1'b1; end
      end
      c_M_BOTH: begin
        if (!cpu_req) begin drive_cpu(rand_req(1'b1)); cpu_req = 1'b1; end
        if (!dbg_req) begin drive_dbg(rand_req(1'b1)); dbg_req = 1'b1; end
      end
      c_M_RANDOM: begin
        if (!cpu_req) begin
          if ($urandom_range(0, 99) < 45) begin drive_cpu(rand_req(1'b0)); cpu_req = 1'b1; end
        end else if ($urandom_range(0, 99) < 4) cpu_req = 1'b0;
        if (!dbg_req) begin
          if ($urandom_range(0, 99) < 45) begin drive_dbg(rand_req(1'b0)); dbg_req = 1'b1; end
        end else if ($urandom_range(0, 99) < 4) dbg_req = 1'b0;
      end
      default: ;
    endcase
  endtask

  // Decide the grant from the arbitration rules, check ready, record it.
  task automatic arbitrate();
    bit ec, ed;
    ec = 1'b0; ed = 1'b0;
    #1;
    if (!busy) begin
      if (dbg_req && (!cpu_req || starve == STARVE_MAX)) ed = 1'b1;
      else if (cpu_req) ec = 1'b1;
      if (ed || !dbg_req) starve = 0;
      else if (ec) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    end
    chk_eq("cpu_ready", 32'(cpu_ready), 32'(ec));
    chk_eq("dbg_ready", 32'(dbg_ready), 32'(ed));
    if (ec || ed) begin
      t_own   = ed ? 2'b10 : 2'b01;
      t_we    = ed ? dbg_we : cpu_we;
      t_addr  = ed ? dbg_addr : cpu_addr;
      t_wdata = ed ? dbg_wdata : cpu_wdata;
      t_size  = ed ? dbg_size : cpu_size;
      t_mis   = misaligned(t_size, t_addr);
      t_exp   = ref_mem[t_addr[7:2]];
      if (t_we && !t_mis) ref_mem[t_addr[7:2]] = t_wdata;
      busy    = 1'b1;
      t_acc   = cyc;
      cpu_acc = ec;
      dbg_acc = ed;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      observe();
      stim();
      arbitrate();
    end
  endtask

  task automatic push_cpu(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [2:0] s);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.size = s;
    cpu_q.push_back(r);
  endtask

  task automatic push_dbg(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [2:0] s);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.size = s;
    dbg_q.push_back(r);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int guard;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_size = 3'b000;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_size = 3'b000;
    for (int i = 0; i < 64; i++) begin
      sim_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    sim_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    cyc = 0; mode = c_M_FIXED; starve = 0; busy = 1'b0; t_acc = 0;
    cpu_acc = 1'b0; dbg_acc = 1'b0; exp_cpu_rd = '0; exp_dbg_rd = '0;
    t_we = 1'b0; t_mis = 1'b0; t_own = 2'b00; t_addr = '0; t_wdata = '0; t_size = '0; t_exp = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_cpu_done", 32'(cpu_done), 32'd0);
    chk_eq("rst_dbg_done", 32'(dbg_done), 32'd0);
    chk_eq("rst_mem_en", 32'(mem_en), 32'd0);
    chk_eq("rst_owner", 32'(owner), 32'd0);
    chk_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk_eq("rst_dbg_rdata", dbg_rdata, 32'd0);
    rst = 1'b0;

    // Single word read, then debug write followed by CPU read-back.
    push_cpu(1'b0, 8'h10, 32'h0, 3'b010);
    run_cycles(5);
    push_dbg(1'b1, 8'h20, 32'h1234_5678, 3'b010);
    run_cycles(5);
    push_cpu(1'b0, 8'h20, 32'h0, 3'b010);
    run_cycles(5);

    // Misaligned word and half accesses.
    push_cpu(1'b0, 8'h06, 32'h0, 3'b010);
    push_cpu(1'b0, 8'h03, 32'h0, 3'b001);
    run_cycles(9);

    // Back-to-back reads: second accept lands on the first done.
    push_cpu(1'b0, 8'h00, 32'h0, 3'b010);
    push_cpu(1'b0, 8'h04, 32'h0, 3'b010);
    run_cycles(9);

    // Both ports saturated: starvation guard cadence.
    mode = c_M_BOTH;
    run_cycles(45);
    mode = c_M_QUIET;
    run_cycles(5);

    mode = c_M_RANDOM;
    run_cycles(3000);
    mode = c_M_QUIET;
    run_cycles(5);

    // Reset while a debug read is in its access cycle.
    mode = c_M_FIXED;
    push_dbg(1'b0, 8'h10, 32'h0, 3'b010);
    guard = 0;
    while (!busy && guard < 10) begin
      run_cycles(1);
      guard++;
    end
    chk_eq("rst_test_accept", 32'(busy), 32'd1);
    @(posedge clk); #1;
    observe();
    stim();
    rst = 1'b1;
    #1;
    chk_eq("async_mem_en", 32'(mem_en), 32'd0);
    chk_eq("async_mem_we", 32'(mem_we), 32'd0);
    chk_eq("async_owner", 32'(owner), 32'd0);
    busy = 1'b0; starve = 0; exp_cpu_rd = '0; exp_dbg_rd = '0;
    @(posedge clk); #1;
    cyc++;
    chk_eq("rst_mid_dbg_done", 32'(dbg_done), 32'd0);
    rst = 1'b0;
    push_cpu(1'b0, 8'h20, 32'h0, 3'b010);
    run_cycles(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter and access sequencer for the single data-memory port. It shares the synchronous-read data memory between the CPU MEM-stage port and a debug/loader port. It runs a fixed three-state access sequence per transaction: CPU has fixed priority over debug, and debug is protected by a starvation counter. Misaligned accesses are rejected without touching memory.

## Interface
- ADDR_W, 8, byte address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive lost arbitrations after which debug wins; must be ≥1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req / dbg_req  in  1  request; fields held stable until ready seen high
- cpu_we / dbg_we  in  1  1 = write, 0 = read
- cpu_addr / dbg_addr  in  ADDR_W  byte address
- cpu_wdata / dbg_wdata  in  DATA_W  write data
- cpu_size / dbg_size  in  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu
- cpu_ready / dbg_ready  out  1  combinational; high in the IDLE cycle the request is accepted
- cpu_done / dbg_done  out  1  registered one-cycle completion pulse
- cpu_err / dbg_err  out  1  registered; valid with done; 1 = misaligned, no access made
- cpu_rdata / dbg_rdata  out  DATA_W  registered read data; valid from done; held until the next read completion on the same port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_size  out  3  memory size select
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the mem_en cycle
- owner  out  2  00 none, 01 cpu, 10 dbg; current transaction owner

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS on any accept.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Arbitration in IDLE:
  - Debug wins when dbg_req=1 and either cpu_req=0 or starve_cnt==STARVE_MAX.
  - Otherwise CPU wins if cpu_req=1.
  - Only the winner's ready goes high.
- Accept latches we, addr, wdata, size, owner and misalign into internal registers. Requester fields are don't-care afterwards.
- Misalign:
  - size[1:0]==10 with addr[1:0]≠0.
  - size[1:0]==01 with addr[0]≠0.
  - size[1:0]==11 is treated as word.
- ACCESS:
  - mem_en=1 unless misaligned.
  - mem_we = latched we & mem_en.
  - mem_addr, mem_wdata, mem_size come from the latched fields.
  - Outside ACCESS: mem_en=0, mem_we=0, other mem_* hold latched values.
- RESP edge (RESP→IDLE):
  - Owner's done ← 1.
  - Owner's err ← misalign.
  - If read and not misaligned, owner's rdata ← mem_rdata.
  - The other port's done is 0.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - +1 on each IDLE accept where CPU wins while dbg_req=1.
  - Cleared on a debug accept, or on any IDLE cycle with dbg_req=0.
  - Saturates at STARVE_MAX.
- owner is 00 in IDLE, otherwise the latched owner.
- Reset, including mid-transaction: state IDLE, all outputs and registers 0, starve_cnt 0. mem_en and mem_we drop asynchronously. An in-flight transaction is dropped with no done.

## Timing
- Accept at cycle T (ready high).
- ACCESS at T+1 (mem_en high).
- RESP at T+2 (mem_rdata sampled).
- done high at T+3 only.
- IDLE at T+3, so a new accept is possible in the same cycle done is high. Back-to-back throughput is one access per 3 cycles.
- ready is combinational from req, state and starve_cnt; it is 0 in ACCESS and RESP.
- Simultaneous cpu_req and dbg_req: CPU wins until STARVE_MAX lost rounds, then debug wins once and the counter clears.
- A request dropped before ready is legal; nothing is latched.

## Test plan
- Single CPU word read, addr 0x10, memory holds 0xDEADBEEF → cpu_ready at T, mem_en at T+1, cpu_done=1 and cpu_rdata=0xDEADBEEF at T+3, cpu_err=0.
- Debug word write 0x12345678 to 0x20, then CPU read of 0x20 → mem_we=1 only at T+1; CPU read returns 0x12345678.
- cpu_req and dbg_req held high continuously, STARVE_MAX=4 → grant order CPU×4, DBG, CPU×4, DBG; no debug grant gap exceeds 4 CPU accepts.
- CPU lw at addr 0x06 and lh at 0x03 → mem_en never asserts; cpu_done=1, cpu_err=1; cpu_rdata keeps its prior value.
- rst asserted during ACCESS of a debug read → mem_en falls within the same cycle; dbg_done is never pulsed; owner=00. After release, a CPU read completes normally in 3 cycles.
- Back-to-back CPU reads 0x00 then 0x04 → second ready in the same cycle as the first cpu_done; each rdata is correct.
